// File: rtl/updown_counter_pkg.sv
// Shared definitions for the up/down counter family: boundary-mode constants,
// the per-cycle action encoding and a constant clog2 for register sizing.
package updown_counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_LOAD,
    ACT_UP,
    ACT_DOWN
  } cnt_act_e;

  // Bits needed to hold values 0..v-1; never returns less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/updown_counter_tick_gen.sv
// Prescaler: pulses tick on every PRESCALE-th enabled cycle. clr restarts the
// period; with PRESCALE=1 it degenerates to tick = en and holds no state.
module tick_gen
  import updown_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
    $error("tick_gen: PRESCALE=%0d outside 1..65536", PRESCALE);
  end

  if (PRESCALE == 1) begin : g_direct
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, clr};
    assign tick = en;
  end else begin : g_count
    localparam int             PW   = clog2(PRESCALE);
    localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;
    logic          at_last;

    assign at_last = (pcnt == LAST);
    assign tick    = en & at_last;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
      if (reset || clr) begin
        pcnt <= '0;
      end else if (en) begin
        pcnt <= at_last ? '0 : pcnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Loadable up/down counter with programmable terminal value, optional
// prescaler and wrap-or-saturate boundaries; q and tc are both registered.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int              N        = 8,
  parameter longint unsigned MAX      = (64'd1 << N) - 64'd1,
  parameter int              PRESCALE = 1,
  parameter int              SATURATE = CNT_WRAP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         tc
);

  if (N < 1 || N > 32) begin : g_bad_n
    $error("updown_counter: N=%0d outside 1..32", N);
  end
  if (MAX == 0 || MAX > ((64'd1 << N) - 64'd1)) begin : g_bad_max
    $error("updown_counter: MAX=%0d illegal for N=%0d", MAX, N);
  end
  if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
    $error("updown_counter: SATURATE=%0d must be 0 or 1", SATURATE);
  end

  localparam logic [N-1:0] MAX_V = MAX[N-1:0];
  localparam bit           SAT   = (SATURATE == CNT_SAT);

  logic         tick;
  logic         at_max;
  logic         at_zero;
  cnt_act_e     act;
  logic [N-1:0] q_next;
  logic         tc_next;

  // A load restarts the prescale period so the next step is a full period away.
  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign at_max  = (q == MAX_V);
  assign at_zero = (q == '0);

  always_comb begin
    act = ACT_IDLE;
    if (load)      act = ACT_LOAD;
    else if (tick) act = up ? ACT_UP : ACT_DOWN;
  end

  // Boundaries are explicit compares so a MAX below 2**N-1 wraps correctly.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    q_next  = q;
    tc_next = 1'b0;
    unique case (act)
      ACT_LOAD: q_next = (d > MAX_V) ? MAX_V : d;
      ACT_UP: begin
        if (at_max) begin
          q_next  = SAT ? MAX_V : '0;
          tc_next = 1'b1;
        end else begin
          q_next = q + N'(1);
        end
      end
      ACT_DOWN: begin
        if (at_zero) begin
          q_next  = SAT ? '0 : MAX_V;
          tc_next = 1'b1;
        end else begin
          q_next = q - N'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q  <= '0;
      tc <= 1'b0;
    end else begin
      q  <= q_next;
      tc <= tc_next;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: four instances cover wrap, mod-10,
// saturate and prescale=3 configurations against a cycle-level model.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst_s  [4];
  logic       en_s   [4];
  logic       up_s   [4];
  logic       load_s [4];
  logic [7:0] d_s    [4];

  logic [7:0] q0, q3;
  logic [3:0] q1, q2;
  logic       tc0, tc1, tc2, tc3;

  always #5 clk = ~clk;

  updown_counter #(.N(8), .MAX(255), .PRESCALE(1), .SATURATE(0)) dut0 (
    .clk(clk), .reset(rst_s[0]), .en(en_s[0]), .up(up_s[0]), .load(load_s[0]),
    .d(d_s[0]), .q(q0), .tc(tc0));
  updown_counter #(.N(4), .MAX(9), .PRESCALE(1), .SATURATE(0)) dut1 (
    .clk(clk), .reset(rst_s[1]), .en(en_s[1]), .up(up_s[1]), .load(load_s[1]),
    .d(d_s[1][3:0]), .q(q1), .tc(tc1));
  updown_counter #(.N(4), .MAX(9), .PRESCALE(1), .SATURATE(1)) dut2 (
    .clk(clk), .reset(rst_s[2]), .en(en_s[2]), .up(up_s[2]), .load(load_s[2]),
    .d(d_s[2][3:0]), .q(q2), .tc(tc2));
  updown_counter #(.N(8), .MAX(255), .PRESCALE(3), .SATURATE(0)) dut3 (
    .clk(clk), .reset(rst_s[3]), .en(en_s[3]), .up(up_s[3]), .load(load_s[3]),
    .d(d_s[3]), .q(q3), .tc(tc3));

  // Model configuration, indexed by instance.
  int   maxv [4] = '{255, 9, 9, 255};
  int   pre  [4] = '{1, 1, 1, 3};
  bit   sat  [4] = '{0, 0, 1, 0};
  int   dmask[4] = '{255, 15, 15, 255};

  int   m_q  [4];
  int   m_p  [4];
  bit   m_tc [4];

  typedef struct {
    string tag;
    int    id;
    int    q;
    bit    tc;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] get_q(input int id);
    case (id)
      0:       return q0;
      1:       return {4'h0, q1};
      2:       return {4'h0, q2};
      default: return q3;
    endcase
  endfunction

  function automatic logic get_tc(input int id);
    case (id)
      0:       return tc0;
      1:       return tc1;
      2:       return tc2;
      default: return tc3;
    endcase
  endfunction

  // Reference behaviour for one clock edge of instance id.
  task automatic model(input int id, input bit rst, input bit ld, input bit e,
                       input bit u, input int dv);
    int dm;
    dm = dv & dmask[id];
    if (rst) begin
      m_q[id] = 0; m_p[id] = 0; m_tc[id] = 0;
    end else if (ld) begin
      m_q[id] = (dm > maxv[id]) ? maxv[id] : dm;
      m_p[id] = 0; m_tc[id] = 0;
    end else if (!e) begin
      m_tc[id] = 0;
    end else if (m_p[id] != pre[id] - 1) begin
      m_p[id]++; m_tc[id] = 0;
    end else begin
      m_p[id] = 0;
      if (u) begin
        m_tc[id] = (m_q[id] == maxv[id]);
        if (m_tc[id]) m_q[id] = sat[id] ? maxv[id] : 0;
        else          m_q[id]++;
      end else begin
        m_tc[id] = (m_q[id] == 0);
        if (m_tc[id]) m_q[id] = sat[id] ? 0 : maxv[id];
        else          m_q[id]--;
      end
    end
  endtask

  task automatic step(input int id, input bit rst, input bit ld, input bit e,
                      input bit u, input int dv, input string tag);
    exp_t x;
    rst_s[id] = rst; load_s[id] = ld; en_s[id] = e; up_s[id] = u; d_s[id] = 8'(dv);
    model(id, rst, ld, e, u, dv);
    sb.push_back('{tag: tag, id: id, q: m_q[id], tc: m_tc[id]});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.tag, ".q"},  32'(get_q(x.id)),  32'(x.q));
    check({x.tag, ".tc"}, 32'(get_tc(x.id)), 32'(x.tc));
    rst_s[id] = 1'b0; load_s[id] = 1'b0; en_s[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    for (int i = 0; i < 4; i++) begin
      rst_s[i] = 1'b1; en_s[i] = 1'b1; up_s[i] = 1'b1; load_s[i] = 1'b1; d_s[i] = 8'h05;
      m_q[i] = 0; m_p[i] = 0; m_tc[i] = 0;
    end
    // Reset dominates load and en.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset%0d.q", i),  32'(get_q(i)),  32'd0);
      check($sformatf("reset%0d.tc", i), 32'(get_tc(i)), 32'd0);
      rst_s[i] = 1'b0; load_s[i] = 1'b0; en_s[i] = 1'b0;
    end

    // Full 8-bit wrap: tc exactly once, when q returns to 0.
    pulses = 0;
    for (int k = 0; k < 256; k++) begin
      step(0, 0, 0, 1, 1, 0, "wrap8");
      if (get_tc(0)) pulses++;
    end
    check("wrap8.final_q", 32'(get_q(0)), 32'd0);
    check("wrap8.pulses", 32'(pulses), 32'd1);
    step(0, 0, 0, 1, 1, 0, "wrap8.after");
    // Load beats a wrapping step and clears tc.
    step(0, 0, 1, 0, 1, 255, "ld255");
    step(0, 0, 1, 1, 1, 7, "ld_over_step");

    // Modulus 10 up, then down from 0 wraps to 9.
    for (int k = 0; k < 10; k++) step(1, 0, 0, 1, 1, 0, "mod10.up");
    check("mod10.wrap_q", 32'(get_q(1)), 32'd0);
    step(1, 0, 0, 1, 0, 0, "mod10.down");
    check("mod10.down_q", 32'(get_q(1)), 32'd9);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 0, 0, "mod10.down2");

    // Saturate: out-of-range load clamps, blocked steps repeat tc.
    step(2, 0, 1, 0, 0, 12, "sat.ld12");
    check("sat.clamp", 32'(get_q(2)), 32'd9);
    for (int k = 0; k < 3; k++) step(2, 0, 0, 1, 1, 0, "sat.hold_max");
    for (int k = 0; k < 9; k++) step(2, 0, 0, 1, 0, 0, "sat.down");
    for (int k = 0; k < 2; k++) step(2, 0, 0, 1, 0, 0, "sat.hold_zero");
    step(2, 0, 0, 0, 0, 0, "sat.idle");

    // Prescale 3: steady, stretched by en gaps, restarted by load.
    for (int k = 0; k < 7; k++) step(3, 0, 0, 1, 1, 0, "ps.run");
    step(3, 0, 0, 0, 1, 0, "ps.gap");
    step(3, 0, 0, 0, 1, 0, "ps.gap");
    for (int k = 0; k < 2; k++) step(3, 0, 0, 1, 1, 0, "ps.resume");
    check("ps.after_gap", 32'(get_q(3)), 32'd3);
    step(3, 0, 1, 1, 1, 16, "ps.load");
    for (int k = 0; k < 3; k++) step(3, 0, 0, 1, 1, 0, "ps.post_load");
    check("ps.post_load_q", 32'(get_q(3)), 32'h11);
    step(3, 0, 0, 1, 0, 0, "ps.dir_change");

    // Simultaneous controls.
    step(3, 1, 1, 1, 1, 5, "sim.rst_ld");
    step(3, 0, 0, 1, 1, 0, "sim.pre");
    step(3, 0, 0, 1, 1, 0, "sim.pre");
    step(3, 0, 1, 1, 1, 7, "sim.ld_step_due");
    step(3, 0, 0, 1, 1, 0, "sim.no_step");

    // Reset mid-count drops the partial prescale.
    step(3, 0, 1, 0, 1, 8'h5A, "midrst.ld");
    step(3, 0, 0, 1, 1, 0, "midrst.p1");
    step(3, 1, 0, 1, 1, 0, "midrst.rst");
    for (int k = 0; k < 3; k++) step(3, 0, 0, 1, 1, 0, "midrst.run");
    check("midrst.first_step", 32'(get_q(3)), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
